alu_share_arbiter: RTL and testbench

//  Shares one ALU instance between NUM_REQ requesters, e.g. the main datapath and a branch/address unit.

---
 rtl/alu_arb_pkg.sv | 19 +
 rtl/alu_share_arbiter_rr_picker.sv | 31 +++
 rtl/alu_share_arbiter.sv | 120 ++++++++++++
 tb/tb_alu_share_arbiter.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_arb_pkg.sv
// Shared types for alu_share_arbiter: ALU op encodings, FSM states and counter width.
package alu_arb_pkg;
  localparam int CNT_W = 16;

  typedef enum logic [3:0] {
    ALU_AND = 4'd0,
    ALU_OR  = 4'd1,
    ALU_ADD = 4'd2,
    ALU_MUL = 4'd3,
    ALU_SUB = 4'd6,
    ALU_SLT = 4'd7,
    ALU_NOR = 4'd12
  } alu_op_e;

  typedef enum logic {
    IDLE = 1'b0,
    EXEC = 1'b1
  } arb_state_e;
endpackage

// File: rtl/alu_share_arbiter_rr_picker.sv
// Combinational round-robin picker: first valid requester scanning upward from rr_ptr+1.
module rr_picker #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);
  int               c;
  logic [IDX_W-1:0] ci;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    c     = 0;
    ci    = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      c  = (int'(rr_ptr) + i) % NUM_REQ;
      ci = IDX_W'(c);
      if (!any && valid[ci]) begin
        any       = 1'b1;
        grant[ci] = 1'b1;
        idx       = ci;
      end
    end
  end
endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one external ALU among NUM_REQ requesters.
// Optional per-requester grant counters behind ALU_ARB_PERF_EN.
module alu_share_arbiter
  import alu_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 32,
  parameter int MUL_LAT = 3
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [NUM_REQ-1:0]          req_valid_i,
  input  logic [4*NUM_REQ-1:0]        req_ctrl_i,
  input  logic [DATA_W*NUM_REQ-1:0]   req_src1_i,
  input  logic [DATA_W*NUM_REQ-1:0]   req_src2_i,
  output logic [NUM_REQ-1:0]          req_ready_o,
  output logic                        rsp_valid_o,
  output logic [$clog2(NUM_REQ)-1:0]  rsp_id_o,
  output logic [DATA_W-1:0]           rsp_result_o,
  output logic                        rsp_zero_o,
  output logic [3:0]                  alu_ctrl_o,
  output logic [DATA_W-1:0]           alu_src1_o,
  output logic [DATA_W-1:0]           alu_src2_o,
  input  logic [DATA_W-1:0]           alu_result_i,
  input  logic                        alu_zero_i,
`ifdef ALU_ARB_PERF_EN
  output logic [CNT_W*NUM_REQ-1:0]    grant_cnt_o,
`endif
  output logic                        busy_o
);
  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CW    = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

  logic [NUM_REQ-1:0][3:0]        ctrl_v;
  logic [NUM_REQ-1:0][DATA_W-1:0] src1_v, src2_v;
  assign ctrl_v = req_ctrl_i;
  assign src1_v = req_src1_i;
  assign src2_v = req_src2_i;

  arb_state_e          state, state_nxt;
  logic [IDX_W-1:0]    rr_ptr, gidx;
  logic [NUM_REQ-1:0]  grant;
  logic                gany, accept;
  logic [CW-1:0]       cnt;

  rr_picker #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_pick (
    .valid  (req_valid_i),
    .rr_ptr (rr_ptr),
    .grant  (grant),
    .idx    (gidx),
    .any    (gany)
  );

  assign accept      = (state == IDLE) && gany;
  assign req_ready_o = (state == IDLE) ? grant : '0;
  assign busy_o      = (state == EXEC);

  always_ff @(posedge clk_i) begin
    if (!rst_i) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = EXEC;
      EXEC: if (cnt == '0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // rr_ptr doubles as the id of the in-flight op, since it is set to the granted index.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      rr_ptr       <= IDX_W'(NUM_REQ-1);
      cnt          <= '0;
      alu_ctrl_o   <= '0;
      alu_src1_o   <= '0;
      alu_src2_o   <= '0;
      rsp_valid_o  <= 1'b0;
      rsp_id_o     <= '0;
      rsp_result_o <= '0;
      rsp_zero_o   <= 1'b0;
    end else begin
      rsp_valid_o <= 1'b0;
      if (accept) begin
        alu_ctrl_o <= ctrl_v[gidx];
        alu_src1_o <= src1_v[gidx];
        alu_src2_o <= src2_v[gidx];
        rr_ptr     <= gidx;
        cnt        <= (ctrl_v[gidx] == 4'(ALU_MUL)) ? CW'(MUL_LAT-1) : '0;
      end else if (state == EXEC) begin
        if (cnt != '0) begin
          cnt <= cnt - 1'b1;
        end else begin
          rsp_valid_o  <= 1'b1;
          rsp_id_o     <= rr_ptr;
          rsp_result_o <= alu_result_i;
          rsp_zero_o   <= alu_zero_i;
        end
      end
    end
  end

`ifdef ALU_ARB_PERF_EN
  logic [NUM_REQ-1:0][CNT_W-1:0] gcnt;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      gcnt <= '0;
    end else begin
      for (int r = 0; r < NUM_REQ; r++)
        if (accept && gidx == IDX_W'(r) && gcnt[r] != '1)
          gcnt[r] <= gcnt[r] + 1'b1;
    end
  end

  assign grant_cnt_o = gcnt;
`endif
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter with a behavioural ALU on the alu_* ports.
module tb_alu_share_arbiter;
  localparam int NR = 2;
  localparam int DW = 32;
  localparam int ML = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst_i;
  logic [NR-1:0]       req_valid = '0;
  logic [4*NR-1:0]     req_ctrl  = '0;
  logic [DW*NR-1:0]    req_src1  = '0;
  logic [DW*NR-1:0]    req_src2  = '0;
  logic [NR-1:0]       req_ready;
  logic                rsp_valid;
  logic                rsp_id;
  logic [DW-1:0]       rsp_result;
  logic                rsp_zero;
  logic [3:0]          alu_ctrl;
  logic [DW-1:0]       alu_src1, alu_src2, alu_result;
  logic                alu_zero;
  logic                busy;
`ifdef ALU_ARB_PERF_EN
  logic [16*NR-1:0]    grant_cnt;
`endif

  alu_share_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .MUL_LAT(ML)) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .req_valid_i  (req_valid),
    .req_ctrl_i   (req_ctrl),
    .req_src1_i   (req_src1),
    .req_src2_i   (req_src2),
    .req_ready_o  (req_ready),
    .rsp_valid_o  (rsp_valid),
    .rsp_id_o     (rsp_id),
    .rsp_result_o (rsp_result),
    .rsp_zero_o   (rsp_zero),
    .alu_ctrl_o   (alu_ctrl),
    .alu_src1_o   (alu_src1),
    .alu_src2_o   (alu_src2),
    .alu_result_i (alu_result),
    .alu_zero_i   (alu_zero),
`ifdef ALU_ARB_PERF_EN
    .grant_cnt_o  (grant_cnt),
`endif
    .busy_o       (busy)
  );

  function automatic logic [DW-1:0] alu_f(input logic [3:0] c, input logic [DW-1:0] a, input logic [DW-1:0] b);
    case (c)
      4'd0:    return a & b;
      4'd1:    return a | b;
      4'd2:    return a + b;
      4'd3:    return a * b;
      4'd6:    return a - b;
      4'd7:    return ($signed(a) < $signed(b)) ? DW'(1) : DW'(0);
      4'd12:   return ~(a | b);
      default: return '0;
    endcase
  endfunction

  always_comb begin
    alu_result = alu_f(alu_ctrl, alu_src1, alu_src2);
    alu_zero   = (alu_result == '0);
  end

  typedef struct { logic [3:0] ctrl; logic [DW-1:0] a; logic [DW-1:0] b; logic [DW-1:0] res; } op_t;
  typedef struct { logic id; logic [DW-1:0] res; logic zero; int due; int lat; } exp_t;

  op_t  pq0[$], pq1[$];
  exp_t sb[$];
  int   gq[$];
  int   n_chk = 0, n_err = 0;
  int   cyc = 0, busy_run = 0, n_acc0 = 0;
  logic [NR-1:0] acc = '0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Requester driver: hold the head op until the monitor saw it accepted.
  always @(posedge clk) begin
    #1;
    if (acc[0]) void'(pq0.pop_front());
    if (acc[1]) void'(pq1.pop_front());
    if (pq0.size() > 0) begin
      req_valid[0] = 1'b1; req_ctrl[3:0] = pq0[0].ctrl;
      req_src1[DW-1:0] = pq0[0].a; req_src2[DW-1:0] = pq0[0].b;
    end else req_valid[0] = 1'b0;
    if (pq1.size() > 0) begin
      req_valid[1] = 1'b1; req_ctrl[7:4] = pq1[0].ctrl;
      req_src1[2*DW-1:DW] = pq1[0].a; req_src2[2*DW-1:DW] = pq1[0].b;
    end else req_valid[1] = 1'b0;
  end

  function automatic exp_t mk_exp(input logic id, input op_t o, input int c);
    exp_t e;
    e.id   = id;
    e.res  = o.res;
    e.zero = (o.res == '0);
    e.lat  = (o.ctrl == 4'd3) ? ML : 1;
    e.due  = c + 1 + e.lat;
    return e;
  endfunction

  always @(negedge clk) begin
    acc = rst_i ? (req_valid & req_ready) : '0;
    if (!rst_i) begin
      sb.delete(); gq.delete(); busy_run = 0; n_acc0 = 0;
    end else begin
      if (busy) chk("ready_in_exec", 64'(req_ready), 0);
      else begin
        chk("ready_subset", 64'(req_ready & ~req_valid), 0);
        chk("ready_onehot", 64'({$onehot0(req_ready), |req_ready}), 64'({1'b1, |req_valid}));
      end
      if (acc[0]) begin sb.push_back(mk_exp(1'b0, pq0[0], cyc)); gq.push_back(0); n_acc0++; end
      if (acc[1]) begin sb.push_back(mk_exp(1'b1, pq1[0], cyc)); gq.push_back(1); end
      if (busy) busy_run++;
      if (rsp_valid) begin
        if (sb.size() == 0) chk("rsp_unexpected", 1, 0);
        else begin
          exp_t e;
          e = sb.pop_front();
          chk("rsp_id", 64'(rsp_id), 64'(e.id));
          chk("rsp_result", 64'(rsp_result), 64'(e.res));
          chk("rsp_zero", 64'(rsp_zero), 64'(e.zero));
          chk("rsp_cycle", 64'(cyc), 64'(e.due));
          chk("busy_len", 64'(busy_run), 64'(e.lat));
        end
        busy_run = 0;
      end
    end
  end

  task automatic send(input int r, input logic [3:0] c, input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [DW-1:0] res);
    op_t o;
    o.ctrl = c; o.a = a; o.b = b; o.res = res;
    if (r == 0) pq0.push_back(o); else pq1.push_back(o);
  endtask

  task automatic drain();
    int t;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while ((pq0.size() != 0 || pq1.size() != 0 || sb.size() != 0 || busy) && t < 300);
    if (t >= 300) chk("drain_timeout", 1, 0);
    @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t;
    rst_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 64'(req_ready), 0);
    chk("rst_rsp_valid", 64'(rsp_valid), 0);
    chk("rst_rsp_id", 64'(rsp_id), 0);
    chk("rst_rsp_result", 64'(rsp_result), 0);
    chk("rst_rsp_zero", 64'(rsp_zero), 0);
    chk("rst_alu_ctrl", 64'(alu_ctrl), 0);
    chk("rst_alu_src", 64'({alu_src1, alu_src2}), 0);
    chk("rst_busy", 64'(busy), 0);
    @(posedge clk); #2 rst_i = 1'b1;
    @(negedge clk);

    send(0, 4'd2, 32'd5, 32'd7, 32'd12);                drain();
    send(1, 4'd6, 32'd9, 32'd9, 32'd0);                 drain();
    send(0, 4'd3, 32'd6, 32'd7, 32'd42);                drain();
    send(1, 4'd7, 32'hFFFF_FFFF, 32'd1, 32'd1);         drain();
    send(0, 4'd0, 32'hF0F0, 32'hFF00, 32'hF000);
    send(1, 4'd12, 32'd0, 32'd0, 32'hFFFF_FFFF);        drain();
    send(1, 4'd5, 32'd3, 32'd4, 32'd0);                 drain();
    send(0, 4'd1, 32'hA, 32'h5, 32'hF);                 drain();
    chk("hold_result", 64'(rsp_result), 64'h0F);

    // Reset in the middle of a MUL: the op must vanish without a response.
    send(0, 4'd3, 32'd3, 32'd3, 32'd9);
    t = 0;
    while (!busy && t < 20) begin @(negedge clk); t++; end
    chk("mul_started", 64'(busy), 1);
    @(posedge clk); #2 rst_i = 1'b0;
    @(posedge clk); #2 rst_i = 1'b1;
    @(negedge clk);
    chk("midrst_busy", 64'(busy), 0);
    chk("midrst_rsp_valid", 64'(rsp_valid), 0);
    chk("midrst_alu_ctrl", 64'(alu_ctrl), 0);
    repeat (5) @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      send(0, 4'd2, 32'(i), 32'd100, 32'(i + 100));
      send(1, 4'd2, 32'(i), 32'd200, 32'(i + 200));
    end
    drain();
    chk("grant_count", 64'(gq.size()), 8);
    for (int i = 0; i < gq.size() && i < 8; i++)
      chk("grant_order", 64'(gq[i]), 64'(i % 2));
    chk("acc0_count", 64'(n_acc0), 4);
`ifdef ALU_ARB_PERF_EN
    chk("perf_cnt0", 64'(grant_cnt[15:0]), 64'(n_acc0));
    chk("perf_cnt1", 64'(grant_cnt[31:16]), 4);
`endif
    chk("sb_empty", 64'(sb.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
